hs_table: RTL and testbench

HS_TABLE -- requirements
Module: hs_table

---
 rtl/hs_table.sv | 197 +++++++++++++++++++
 tb/tb_hs_table.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_table.sv
// ---------------------------------------------------------------------------
// HsTable : sorted high-score table
//
// Keeps DEPTH unsigned scores in descending order (index 0 = highest).
// A new score is inserted by a small FSM that first scans the table for the
// first entry it strictly beats, then ripples the lower entries down by one
// slot (dropping the old last entry) and finally writes the score into the
// freed slot. Ties rank below the existing entry, so a score of zero can
// never displace an empty (zero) slot.
//
// Ports
//   clk        : single rising-edge clock
//   reset      : synchronous, active-high reset
//   ins_valid  : insert request, only looked at while idle
//   ins_score  : score to insert
//   ins_ready  : block is idle and can accept an insert
//   ins_done   : one-cycle pulse when an insert completes
//   ins_placed : last completed insert entered the table
//   ins_rank   : index taken by the last placed score
//   clr        : zero every entry (only acted upon while idle)
//   rd_en      : read strobe
//   rd_addr    : read index (0 = highest score)
//   rd_data    : registered read data, zero for out-of-range indices
//   busy       : an insert is in progress (inverse of ins_ready)
// ---------------------------------------------------------------------------
module hs_table #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ins_valid,
    input  logic [DATA_W-1:0] ins_score,
    output logic              ins_ready,
    output logic              ins_done,
    output logic              ins_placed,
    output logic [AW-1:0]     ins_rank,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    // Index of the bottom entry, and DEPTH widened by one bit so that the
    // read-range check also works when DEPTH is a power of two.
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);
    localparam logic [AW:0]   DepthL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_e;

    state_e            state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] score_q, score_d;
    logic [AW-1:0]     scan_q, scan_d;
    logic [AW-1:0]     shj_q, shj_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic [AW-1:0]     rank_q, rank_d;
    logic              placed_q, placed_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              clear_en;
    logic              shift_en;
    logic              place_en;
    logic              addr_ok;

    // State register and the insert bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            score_q   <= '0;
            scan_q    <= '0;
            shj_q     <= '0;
            pos_q     <= '0;
            rank_q    <= '0;
            placed_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            scan_q    <= scan_d;
            shj_q     <= shj_d;
            pos_q     <= pos_d;
            rank_q    <= rank_d;
            placed_q  <= placed_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state logic. The scan walks down from the top until the new
    // score strictly beats an entry; the shift phase then walks j back up
    // from the bottom, copying each entry from the one above it, and the
    // final SHIFT cycle (j == pos) drops the new score into place.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        scan_d   = scan_q;
        shj_d    = shj_q;
        pos_d    = pos_q;
        rank_d   = rank_q;
        placed_d = placed_q;
        clear_en = 1'b0;
        shift_en = 1'b0;
        place_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    clear_en = 1'b1;
                end else if (ins_valid) begin
                    score_d = ins_score;
                    scan_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (score_q > mem_q[scan_q]) begin
                    pos_d   = scan_q;
                    shj_d   = LastIdx;
                    state_d = SHIFT;
                end else if (scan_q == LastIdx) begin
                    placed_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            SHIFT: begin
                if (shj_q > pos_q) begin
                    shift_en = 1'b1;
                    shj_d    = shj_q - 1'b1;
                end else begin
                    place_en = 1'b1;
                    placed_d = 1'b1;
                    rank_d   = pos_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state only.
    always_comb begin
        ins_ready = 1'b0;
        ins_done  = 1'b0;
        unique case (state_q)
            IDLE:    ins_ready = 1'b1;
            DONE:    ins_done  = 1'b1;
            default: ins_ready = 1'b0;
        endcase
        busy = ~ins_ready;
    end

    assign ins_placed = placed_q;
    assign ins_rank   = rank_q;
    assign rd_data    = rd_data_q;

    // Score storage. The shift copies mem[j-1] into mem[j]; since the bottom
    // slot is the first destination, the old last entry is simply lost.
    always_ff @(posedge clk) begin
        if (reset || clear_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (shift_en) begin
            mem_q[shj_q] <= mem_q[shj_q - 1'b1];
        end else if (place_en) begin
            mem_q[pos_q] <= score_q;
        end
    end

    // Read port samples the array as it stands before this edge's write or
    // clear, so a read alongside a shift or clear sees the old contents.
    assign addr_ok = ({1'b0, rd_addr} < DepthL);

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = addr_ok ? mem_q[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_hs_table.sv
// ---------------------------------------------------------------------------
// Self-checking bench for hs_table (DEPTH = 3, DATA_W = 32).
// Inserts are driven from a table of vectors; expected completion data goes
// into a scoreboard queue when the insert is issued and is popped when the
// DUT pulses ins_done. Read expectations use a second queue in the same way.
// ---------------------------------------------------------------------------
module tb_hs_table;

    localparam int DW = 32;
    localparam int DP = 3;
    localparam int AWB = 2;
    localparam int MaxWait = 40;

    logic           clk;
    logic           reset;
    logic           ins_valid;
    logic [DW-1:0]  ins_score;
    logic           ins_ready;
    logic           ins_done;
    logic           ins_placed;
    logic [AWB-1:0] ins_rank;
    logic           clr;
    logic           rd_en;
    logic [AWB-1:0] rd_addr;
    logic [DW-1:0]  rd_data;
    logic           busy;

    int checks = 0;
    int errors = 0;

    typedef enum logic {OpIns, OpClr} op_e;

    typedef struct {
        op_e           op;
        logic [DW-1:0] score;
        logic          expPlaced;
        logic [1:0]    expRank;
        int            expLat;
        logic [DW-1:0] t0;
        logic [DW-1:0] t1;
        logic [DW-1:0] t2;
    } vec_t;

    typedef struct {
        logic       placed;
        logic [1:0] rank;
        logic       chkRank;
        int         lat;
    } insExp_t;

    insExp_t       insQ[$];
    logic [DW-1:0] rdQ[$];
    vec_t          vecs[13];

    hs_table #(
        .DATA_W(DW),
        .DEPTH (DP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ins_valid (ins_valid),
        .ins_score (ins_score),
        .ins_ready (ins_ready),
        .ins_done  (ins_done),
        .ins_placed(ins_placed),
        .ins_rank  (ins_rank),
        .clr       (clr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pops the scoreboard once ins_done has been seen (or the wait expired)
    // and compares latency, placement and rank, then checks the pulse ends.
    task automatic collectDone(input int cyc);
        insExp_t e;
        if (!ins_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL insTimeout: no ins_done after %0d cycles", cyc);
            if (insQ.size() > 0) void'(insQ.pop_front());
            return;
        end
        if (insQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL insUnexpected: ins_done with empty scoreboard");
            return;
        end
        e = insQ.pop_front();
        checkOutput("insLatency", DW'(cyc), DW'(e.lat));
        checkOutput("insPlaced", DW'(ins_placed), DW'(e.placed));
        if (e.chkRank) checkOutput("insRank", DW'(ins_rank), DW'(e.rank));
        @(negedge clk);
        checkOutput("doneOneCycle", DW'(ins_done), 32'd0);
        checkOutput("readyAfterDone", DW'(ins_ready), 32'd1);
    endtask

    // Issues one insert and follows it through to completion.
    task automatic applyStimulus(input logic [DW-1:0] score, input logic expPlaced,
                                 input logic [1:0] expRank, input int expLat);
        insExp_t e;
        int cyc;
        e = '{expPlaced, expRank, expPlaced, expLat};
        insQ.push_back(e);
        ins_valid = 1'b1;
        ins_score = score;
        @(negedge clk);
        ins_valid = 1'b0;
        checkOutput("busyAfterAccept", DW'(busy), 32'd1);
        cyc = 1;
        while (!ins_done && cyc < MaxWait) begin
            @(negedge clk);
            cyc++;
        end
        collectDone(cyc);
    endtask

    task automatic readOne(input logic [AWB-1:0] addr, input logic [DW-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        rdQ.push_back(exp);
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("readOne", rd_data, rdQ.pop_front());
    endtask

    // Back-to-back reads of indices 0..2, one result per cycle.
    task automatic readTable(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2);
        rdQ.push_back(e0);
        rdQ.push_back(e1);
        rdQ.push_back(e2);
        for (int a = 0; a < DP; a++) begin
            rd_en   = 1'b1;
            rd_addr = AWB'(a);
            @(negedge clk);
            checkOutput("tableEntry", rd_data, rdQ.pop_front());
        end
        rd_en = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        int cyc;
        int sawDone;
        insExp_t e;

        // Insert/clear vectors with hand-computed results for DEPTH = 3.
        vecs[0]  = '{OpIns, 32'd100, 1'b1, 2'd0, 5, 32'd100, 32'd0,   32'd0};
        vecs[1]  = '{OpIns, 32'd50,  1'b1, 2'd1, 5, 32'd100, 32'd50,  32'd0};
        vecs[2]  = '{OpIns, 32'd20,  1'b1, 2'd2, 5, 32'd100, 32'd50,  32'd20};
        vecs[3]  = '{OpIns, 32'd70,  1'b1, 2'd1, 5, 32'd100, 32'd70,  32'd50};
        vecs[4]  = '{OpClr, 32'd0,   1'b0, 2'd0, 0, 32'd0,   32'd0,   32'd0};
        vecs[5]  = '{OpIns, 32'd0,   1'b0, 2'd0, 4, 32'd0,   32'd0,   32'd0};
        vecs[6]  = '{OpIns, 32'd100, 1'b1, 2'd0, 5, 32'd100, 32'd0,   32'd0};
        vecs[7]  = '{OpIns, 32'd50,  1'b1, 2'd1, 5, 32'd100, 32'd50,  32'd0};
        vecs[8]  = '{OpIns, 32'd20,  1'b1, 2'd2, 5, 32'd100, 32'd50,  32'd20};
        vecs[9]  = '{OpIns, 32'd20,  1'b0, 2'd0, 4, 32'd100, 32'd50,  32'd20};
        vecs[10] = '{OpIns, 32'd5,   1'b0, 2'd0, 4, 32'd100, 32'd50,  32'd20};
        vecs[11] = '{OpIns, 32'd200, 1'b1, 2'd0, 5, 32'd200, 32'd100, 32'd50};
        vecs[12] = '{OpIns, 32'd60,  1'b1, 2'd2, 5, 32'd200, 32'd100, 32'd60};

        reset     = 1'b1;
        ins_valid = 1'b0;
        ins_score = '0;
        clr       = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstReady", DW'(ins_ready), 32'd1);
        checkOutput("rstBusy", DW'(busy), 32'd0);
        checkOutput("rstDone", DW'(ins_done), 32'd0);
        checkOutput("rstPlaced", DW'(ins_placed), 32'd0);
        checkOutput("rstRank", DW'(ins_rank), 32'd0);
        checkOutput("rstRdData", rd_data, 32'd0);

        // Table-driven inserts and clears, table read back after each.
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].op == OpClr) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end else begin
                applyStimulus(vecs[v].score, vecs[v].expPlaced, vecs[v].expRank,
                              vecs[v].expLat);
            end
            readTable(vecs[v].t0, vecs[v].t1, vecs[v].t2);
        end

        // clr together with ins_valid while idle: clear wins, read same edge
        // still returns the pre-clear value, and no insert starts.
        clr       = 1'b1;
        ins_valid = 1'b1;
        ins_score = 32'd999;
        rd_en     = 1'b1;
        rd_addr   = 2'd0;
        rdQ.push_back(32'd200);
        @(negedge clk);
        clr       = 1'b0;
        ins_valid = 1'b0;
        rd_en     = 1'b0;
        checkOutput("rdWithClr", rd_data, rdQ.pop_front());
        checkOutput("clrBusy", DW'(busy), 32'd0);
        sawDone = 0;
        for (int c = 0; c < 6; c++) begin
            if (ins_done || busy) sawDone++;
            @(negedge clk);
        end
        checkOutput("clrNoInsert", DW'(sawDone), 32'd0);
        readTable(32'd0, 32'd0, 32'd0);

        // Rebuild 100,50,20.
        applyStimulus(32'd100, 1'b1, 2'd0, 5);
        applyStimulus(32'd50, 1'b1, 2'd1, 5);
        applyStimulus(32'd20, 1'b1, 2'd2, 5);

        // Insert 70; during the first SHIFT cycle (c3) pulse clr, a stray
        // ins_valid and a read of index 2, which must see the pre-shift 20.
        e = '{1'b1, 2'd1, 1'b1, 5};
        insQ.push_back(e);
        ins_valid = 1'b1;
        ins_score = 32'd70;
        @(negedge clk);
        ins_valid = 1'b0;
        cyc = 1;
        while (!ins_done && cyc < MaxWait) begin
            if (cyc == 3) begin
                clr       = 1'b1;
                ins_valid = 1'b1;
                ins_score = 32'd999;
                rd_en     = 1'b1;
                rd_addr   = 2'd2;
                rdQ.push_back(32'd20);
            end
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                clr       = 1'b0;
                ins_valid = 1'b0;
                rd_en     = 1'b0;
                checkOutput("rdDuringShift", rd_data, rdQ.pop_front());
            end
        end
        collectDone(cyc);
        sawDone = 0;
        for (int c = 0; c < 6; c++) begin
            if (ins_done || busy) sawDone++;
            @(negedge clk);
        end
        checkOutput("validIgnoredBusy", DW'(sawDone), 32'd0);
        readTable(32'd100, 32'd70, 32'd50);

        // Out-of-range read, then an in-range read to leave rd_data nonzero.
        readOne(2'd3, 32'd0);
        readOne(2'd0, 32'd100);

        // Reset pulsed at c2 of an insert: aborted, no ins_done, table zeroed.
        ins_valid = 1'b1;
        ins_score = 32'd500;
        @(negedge clk);
        ins_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortReady", DW'(ins_ready), 32'd1);
        checkOutput("abortBusy", DW'(busy), 32'd0);
        checkOutput("abortPlaced", DW'(ins_placed), 32'd0);
        checkOutput("abortRank", DW'(ins_rank), 32'd0);
        checkOutput("abortRdData", rd_data, 32'd0);
        sawDone = 0;
        for (int c = 0; c < 8; c++) begin
            if (ins_done) sawDone++;
            @(negedge clk);
        end
        checkOutput("abortNoDone", DW'(sawDone), 32'd0);
        readTable(32'd0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
